// File: rtl/alu_multicycle.sv
// EX-stage ALU for the multi-cycle MIPS core: single-cycle logic/arith/compare ops
// plus iterative unsigned multiply/divide, issued with a start/done handshake.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUctrlop,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] ALUresult,
    output logic [WIDTH-1:0] hi,
    output logic             Zero,
    output logic             ovf,
    output logic             dbz,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1000;
    localparam logic [3:0] OP_XOR   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_b, r_hi, r_lo;

    logic              w_accept, w_iter, w_last;
    logic [WIDTH-1:0]  w_sum, w_diff, w_res, w_hi;
    logic              w_ovf, w_dbz;
    logic [WIDTH:0]    w_madd, w_shift, w_dsub;
    logic [WIDTH-1:0]  w_step_hi, w_step_lo;

    assign w_accept = start && (r_state != S_RUN);
    assign w_iter   = (ALUctrlop == OP_MULTU) || ((ALUctrlop == OP_DIVU) && (in1 != '0));
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) w_state_nxt = w_iter ? S_RUN : S_DONE;
                else          w_state_nxt = S_IDLE;
            end
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_sum  = in0 + in1;
    assign w_diff = in0 - in1;

    // Single-cycle result; divu only lands here when the divisor is zero.
    always_comb begin
        w_res = '0;
        w_hi  = '0;
        w_ovf = 1'b0;
        w_dbz = 1'b0;
        case (ALUctrlop)
            OP_AND:  w_res = in0 & in1;
            OP_OR:   w_res = in0 | in1;
            OP_NOR:  w_res = ~(in0 | in1);
            OP_XOR:  w_res = in0 ^ in1;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (in0[WIDTH-1] == in1[WIDTH-1]) && (w_sum[WIDTH-1] != in0[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (in0[WIDTH-1] != in1[WIDTH-1]) && (w_diff[WIDTH-1] != in0[WIDTH-1]);
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (in0 < in1)};
            OP_DIVU: begin
                w_res = '1;
                w_hi  = in0;
                w_dbz = 1'b1;
            end
            default: w_res = '0;
        endcase
    end

    // Multiply: {r_hi,r_lo} is the product/multiplier pair shifted right each step.
    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_dsub  = w_shift - {1'b0, r_b};

    always_comb begin
        if (r_op == OP_MULTU) begin
            w_step_hi = w_madd[WIDTH:1];
            w_step_lo = {w_madd[0], r_lo[WIDTH-1:1]};
        end else begin
            w_step_hi = w_dsub[WIDTH] ? w_shift[WIDTH-1:0] : w_dsub[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], ~w_dsub[WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_cnt     <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            ALUresult <= '0;
            hi        <= '0;
            Zero      <= 1'b0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else if (w_accept) begin
            r_op  <= ALUctrlop;
            r_cnt <= '0;
            r_hi  <= '0;
            r_b   <= (ALUctrlop == OP_MULTU) ? in0 : in1;
            r_lo  <= (ALUctrlop == OP_MULTU) ? in1 : in0;
            if (!w_iter) begin
                ALUresult <= w_res;
                hi        <= w_hi;
                Zero      <= (w_res == '0);
                ovf       <= w_ovf;
                dbz       <= w_dbz;
            end
        end else if (r_state == S_RUN) begin
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                ALUresult <= w_step_lo;
                hi        <= w_step_hi;
                Zero      <= (w_step_lo == '0);
                ovf       <= 1'b0;
                dbz       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a 32-bit instance for the main sequence and an
// 8-bit instance for the narrow multiply.
module tb_alu_multicycle;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SLTU = 4'b0011, OP_SUB = 4'b0110, OP_SLT = 4'b0111,
                           OP_NOR = 4'b1000, OP_XOR = 4'b1001, OP_MULTU = 4'b1100,
                           OP_DIVU = 4'b1101, OP_BAD = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start8;
    logic [3:0]  op, op8;
    logic [31:0] a, b, res, hi;
    logic [7:0]  a8, b8, res8, hi8;
    logic        zero, ovf, dbz, busy, done;
    logic        zero8, ovf8, dbz8, busy8, done8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUctrlop(op), .in0(a), .in1(b),
        .ALUresult(res), .hi(hi), .Zero(zero), .ovf(ovf), .dbz(dbz), .busy(busy), .done(done)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ALUctrlop(op8), .in0(a8), .in1(b8),
        .ALUresult(res8), .hi(hi8), .Zero(zero8), .ovf(ovf8), .dbz(dbz8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge of the cycle after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, nbusy;
        logic seen;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        #12;
        chk("rst_res", res, 0);
        chk("rst_hi", hi, 0);
        chk("rst_flags", {zero, ovf, dbz, busy, done}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Reset in the middle of a multiply: everything clears, no done ever appears.
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_res", {res, hi}, 0);
        chk("midrst_flags", {zero, ovf, dbz, busy, done}, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("midrst_nodone", seen, 0);

        issue(OP_ADD, 32'd5, 32'd7);
        chk("add_done", done, 1);
        chk("add_res", res, 32'd12);
        chk("add_flags", {zero, ovf, dbz, busy}, 0);
        chk("add_hi", hi, 0);

        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        chk("addovf_res", res, 32'h8000_0000);
        chk("addovf_ovf", ovf, 1);

        issue(OP_SUB, 32'h8000_0000, 32'd1);
        chk("subovf_res", res, 32'h7FFF_FFFF);
        chk("subovf_ovf", ovf, 1);

        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        chk("slt_res", {res, zero, ovf}, {32'd1, 1'b0, 1'b0});
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_res", {res, zero}, {32'd0, 1'b1});

        issue(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
        chk("or_res", res, 32'hF0F0_0F0F);
        issue(OP_NOR, 32'h0, 32'h0000_00FF);
        chk("nor_res", res, 32'hFFFF_FF00);

        issue(OP_SUB, 32'd9, 32'd9);
        chk("sub0_res", {res, zero, ovf}, {32'd0, 1'b1, 1'b0});

        // Multiply with spurious start pulses while busy; outputs hold the old result.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        lat = 1; nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            if (lat == 2) chk("mul_hold", {res, zero}, {32'd0, 1'b1});
            if (lat == 5) begin start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1; end
            if (lat == 6) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("mul_lat", lat, 33);
        chk("mul_busy", nbusy, 32);
        chk("mul_hi", hi, 32'hFFFF_FFFE);
        chk("mul_lo", res, 32'h0000_0001);
        chk("mul_flags", {zero, ovf, dbz}, 0);
        @(negedge clk);
        chk("mul_idle", {done, busy}, 0);

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat);
        chk("div_lat", lat, 33);
        chk("div_q", res, 32'd14);
        chk("div_r", hi, 32'd2);
        chk("div_dbz", dbz, 0);

        issue(OP_DIVU, 32'd100, 32'd0);
        chk("dbz_done", {done, busy}, 2'b10);
        chk("dbz_res", res, 32'hFFFF_FFFF);
        chk("dbz_hi", hi, 32'd100);
        chk("dbz_flag", {dbz, zero}, 2'b10);

        // Back-to-back: second start lands in the first op's done cycle.
        @(negedge clk);
        start = 1'b1; op = OP_AND; a = 32'hF0; b = 32'h3C;
        @(negedge clk);
        chk("b2b_done1", done, 1);
        chk("b2b_res1", res, 32'h30);
        op = OP_XOR;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done2", done, 1);
        chk("b2b_res2", res, 32'hCC);
        @(negedge clk);
        chk("b2b_idle", done, 0);

        issue(OP_BAD, 32'd5, 32'd3);
        chk("bad_res", {done, res, zero, ovf, dbz}, {1'b1, 32'd0, 1'b1, 1'b0, 1'b0});

        // Narrow instance.
        @(negedge clk);
        start8 = 1'b1; op8 = OP_MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("mul8_lat", lat, 9);
        chk("mul8_hi", hi8, 8'hFE);
        chk("mul8_lo", res8, 8'h01);
        chk("mul8_flags", {zero8, ovf8, dbz8, busy8}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
